// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch vs. data port sharing one memory port.
// Data wins in IDLE unless it has starved fetch for MAX_DM_STREAK consecutive grants.
module mem_arbiter #(
  parameter int LATENCY       = 2,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic        IF_GNT,
  output logic        IF_VALID,
  output logic [31:0] IF_RDATA,
  input  logic        DM_REQ,
  input  logic        DM_WE,
  input  logic [31:0] DM_ADDR,
  input  logic [31:0] DM_WDATA,
  input  logic [2:0]  DM_FUNC3,
  output logic        DM_GNT,
  output logic        DM_VALID,
  output logic [31:0] DM_RDATA,
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [2:0]  MEM_FUNC3,
  input  logic [31:0] MEM_RDATA,
  output logic        BUSY
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACC_IF = 2'd1;
  localparam logic [1:0] ACC_DM = 2'd2;

  localparam logic [2:0] CNT_LOAD   = 3'(LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic [3:0]  streak;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_we;
  logic [2:0]  acc_func3;
  logic        idle;
  logic        if_wins;

  assign idle = (state == IDLE);
  assign BUSY = !idle;

  always_comb begin
    if_wins = IF_REQ && (!DM_REQ || (streak >= STREAK_MAX));
    IF_GNT  = !RESET && idle && if_wins;
    DM_GNT  = !RESET && idle && DM_REQ && !if_wins;
  end

  always_comb begin
    MEM_EN    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    MEM_FUNC3 = '0;
    if (!idle) begin
      MEM_EN    = 1'b1;
      MEM_WE    = acc_we;
      MEM_ADDR  = acc_addr;
      MEM_WDATA = acc_wdata;
      MEM_FUNC3 = acc_func3;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      streak    <= '0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      acc_we    <= 1'b0;
      acc_func3 <= '0;
      IF_RDATA  <= '0;
      DM_RDATA  <= '0;
      IF_VALID  <= 1'b0;
      DM_VALID  <= 1'b0;
    end else begin
      IF_VALID <= 1'b0;
      DM_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (DM_GNT) begin
            acc_addr  <= DM_ADDR;
            acc_wdata <= DM_WDATA;
            acc_we    <= DM_WE;
            acc_func3 <= DM_FUNC3;
            cnt       <= CNT_LOAD;
            state     <= ACC_DM;
            if (streak != 4'hF) streak <= streak + 4'd1;
          end else if (IF_GNT) begin
            acc_addr  <= IF_ADDR;
            acc_wdata <= '0;
            acc_we    <= 1'b0;
            acc_func3 <= 3'b010;
            cnt       <= CNT_LOAD;
            state     <= ACC_IF;
            streak    <= '0;
          end else if (!DM_REQ) begin
            streak <= '0;
          end
        end
        ACC_IF, ACC_DM: begin
          if (cnt == '0) begin
            state <= IDLE;
            if (state == ACC_IF) begin
              IF_RDATA <= MEM_RDATA;
              IF_VALID <= 1'b1;
            end else begin
              DM_RDATA <= acc_we ? '0 : MEM_RDATA;
              DM_VALID <= 1'b1;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-by-cycle vector table plus streak and LATENCY=1 sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [2:0]  dm_func3;
  logic        if_gnt, if_valid, dm_gnt, dm_valid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_func3;

  logic        if_req2;
  logic [31:0] if_addr2, mem_rdata2;
  logic        z1;
  logic [31:0] z32;
  logic [2:0]  z3;
  logic        if_gnt2, if_valid2, dm_gnt2, dm_valid2, mem_en2, mem_we2, busy2;
  logic [31:0] if_rdata2, dm_rdata2, mem_addr2, mem_wdata2;
  logic [2:0]  mem_func32;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(2), .MAX_DM_STREAK(4)) dut (
    .CLK(clk), .RESET(rst),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_GNT(if_gnt), .IF_VALID(if_valid), .IF_RDATA(if_rdata),
    .DM_REQ(dm_req), .DM_WE(dm_we), .DM_ADDR(dm_addr), .DM_WDATA(dm_wdata), .DM_FUNC3(dm_func3),
    .DM_GNT(dm_gnt), .DM_VALID(dm_valid), .DM_RDATA(dm_rdata),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_FUNC3(mem_func3), .MEM_RDATA(mem_rdata), .BUSY(busy)
  );

  mem_arbiter #(.LATENCY(1), .MAX_DM_STREAK(4)) dut_lat1 (
    .CLK(clk), .RESET(rst),
    .IF_REQ(if_req2), .IF_ADDR(if_addr2), .IF_GNT(if_gnt2), .IF_VALID(if_valid2), .IF_RDATA(if_rdata2),
    .DM_REQ(z1), .DM_WE(z1), .DM_ADDR(z32), .DM_WDATA(z32), .DM_FUNC3(z3),
    .DM_GNT(dm_gnt2), .DM_VALID(dm_valid2), .DM_RDATA(dm_rdata2),
    .MEM_EN(mem_en2), .MEM_WE(mem_we2), .MEM_ADDR(mem_addr2), .MEM_WDATA(mem_wdata2),
    .MEM_FUNC3(mem_func32), .MEM_RDATA(mem_rdata2), .BUSY(busy2)
  );

  typedef struct {
    string       name;
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        dmr, we;
    logic [31:0] dma, wd;
    logic [2:0]  f3;
    logic [31:0] mrd;
    logic [137:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(string name, logic r, logic ifr, logic [31:0] ifa, logic dmr, logic we,
                              logic [31:0] dma, logic [31:0] wd, logic [2:0] f3, logic [31:0] mrd,
                              logic ifg, logic dmg, logic en, logic mwe, logic [31:0] ma,
                              logic [31:0] mwd, logic [2:0] mf3, logic ifv, logic [31:0] ifd,
                              logic dmv, logic [31:0] dmd, logic bsy);
    vec_t v;
    v.name = name; v.rst = r; v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.we = we;
    v.dma = dma; v.wd = wd; v.f3 = f3; v.mrd = mrd;
    v.exp = {ifg, dmg, en, mwe, ma, mwd, mf3, ifv, ifd, dmv, dmd, bsy};
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  initial begin
    logic [137:0] obs;
    string        seq;
    byte          got;

    // name, rst,ifr,ifa, dmr,we,dma,wd,f3, mrd | ifg,dmg,en,mwe,ma,mwd,mf3, ifv,ifd, dmv,dmd, busy
    tbl.push_back(mk("rst_hold",      1,1,'h40, 1,0,'h1000,0,0, 0,          0,0,0,0,0,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk("if_gnt",        0,1,'h40, 0,0,0,0,0, 0,               1,0,0,0,0,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk("if_acc1",       0,0,0, 0,0,0,0,0, 'h11111111,         0,0,1,0,'h40,0,2, 0,0, 0,0, 1));
    tbl.push_back(mk("if_acc2",       0,0,0, 0,0,0,0,0, 'h00500093,         0,0,1,0,'h40,0,2, 0,0, 0,0, 1));
    tbl.push_back(mk("if_valid",      0,0,0, 0,0,0,0,0, 0,                  0,0,0,0,0,0,0, 1,'h00500093, 0,0, 0));
    tbl.push_back(mk("dm_wins",       0,1,'h44, 1,0,'h1000,0,4, 0,          0,1,0,0,0,0,0, 0,'h00500093, 0,0, 0));
    tbl.push_back(mk("dm_acc1",       0,1,'h44, 0,0,0,0,0, 0,               0,0,1,0,'h1000,0,4, 0,'h00500093, 0,0, 1));
    tbl.push_back(mk("dm_acc2",       0,1,'h44, 0,0,0,0,0, 'hAB,            0,0,1,0,'h1000,0,4, 0,'h00500093, 0,0, 1));
    tbl.push_back(mk("dm_valid_ifgnt",0,1,'h44, 0,0,0,0,0, 0,               1,0,0,0,0,0,0, 0,'h00500093, 1,'hAB, 0));
    tbl.push_back(mk("if2_acc1",      0,0,0, 0,0,0,0,0, 0,                  0,0,1,0,'h44,0,2, 0,'h00500093, 0,'hAB, 1));
    tbl.push_back(mk("if2_acc2",      0,0,0, 0,0,0,0,0, 'h12345678,         0,0,1,0,'h44,0,2, 0,'h00500093, 0,'hAB, 1));
    tbl.push_back(mk("if2_valid",     0,0,0, 0,0,0,0,0, 0,                  0,0,0,0,0,0,0, 1,'h12345678, 0,'hAB, 0));
    tbl.push_back(mk("st_gnt",        0,0,0, 1,1,'h2000,'hDEADBEEF,2, 0,    0,1,0,0,0,0,0, 0,'h12345678, 0,'hAB, 0));
    tbl.push_back(mk("st_acc1",       0,0,0, 1,0,'h3000,0,0, 'hFFFFFFFF,    0,0,1,1,'h2000,'hDEADBEEF,2, 0,'h12345678, 0,'hAB, 1));
    tbl.push_back(mk("st_acc2",       0,0,0, 1,0,'h3000,0,0, 'hCAFEF00D,    0,0,1,1,'h2000,'hDEADBEEF,2, 0,'h12345678, 0,'hAB, 1));
    tbl.push_back(mk("st_valid_ldgnt",0,0,0, 1,0,'h3000,0,0, 0,             0,1,0,0,0,0,0, 0,'h12345678, 1,0, 0));
    tbl.push_back(mk("ld_acc1",       0,0,0, 0,0,0,0,0, 0,                  0,0,1,0,'h3000,0,0, 0,'h12345678, 0,0, 1));
    tbl.push_back(mk("ld_acc2",       0,0,0, 0,0,0,0,0, 'h55,               0,0,1,0,'h3000,0,0, 0,'h12345678, 0,0, 1));
    tbl.push_back(mk("ld_valid",      0,0,0, 0,0,0,0,0, 0,                  0,0,0,0,0,0,0, 0,'h12345678, 1,'h55, 0));
    tbl.push_back(mk("if3_gnt",       0,1,'h80, 0,0,0,0,0, 0,               1,0,0,0,0,0,0, 0,'h12345678, 0,'h55, 0));
    tbl.push_back(mk("if3_acc1",      0,0,0, 0,0,0,0,0, 0,                  0,0,1,0,'h80,0,2, 0,'h12345678, 0,'h55, 1));
    tbl.push_back(mk("rst_in_acc",    1,1,'h84, 0,0,0,0,0, 'h99999999,      0,0,1,0,'h80,0,2, 0,'h12345678, 0,'h55, 1));
    tbl.push_back(mk("post_rst_gnt",  0,1,'h84, 0,0,0,0,0, 0,               1,0,0,0,0,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk("if4_acc1_dmreq",0,0,0, 1,0,'h5000,0,2, 0,             0,0,1,0,'h84,0,2, 0,0, 0,0, 1));
    tbl.push_back(mk("if4_acc2_drop", 0,0,0, 0,0,0,0,0, 'h77,               0,0,1,0,'h84,0,2, 0,0, 0,0, 1));
    tbl.push_back(mk("if4_valid",     0,0,0, 0,0,0,0,0, 0,                  0,0,0,0,0,0,0, 1,'h77, 0,0, 0));

    rst = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
    dm_wdata = '0; dm_func3 = '0; mem_rdata = '0;
    if_req2 = 0; if_addr2 = '0; mem_rdata2 = '0; z1 = 0; z32 = '0; z3 = '0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      rst = tbl[i].rst; if_req = tbl[i].ifr; if_addr = tbl[i].ifa; dm_req = tbl[i].dmr;
      dm_we = tbl[i].we; dm_addr = tbl[i].dma; dm_wdata = tbl[i].wd; dm_func3 = tbl[i].f3;
      mem_rdata = tbl[i].mrd;
      @(negedge clk);
      obs = {if_gnt, dm_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_func3,
             if_valid, if_rdata, dm_valid, dm_rdata, busy};
      total++;
      if (obs === tbl[i].exp) passed++;
      else $display("FAIL vec%0d %s: got 0x%035h required 0x%035h", i, tbl[i].name, obs, tbl[i].exp);
      @(posedge clk);
      #1;
    end

    // Both requesters held: four data grants, one fetch, then data again.
    rst = 0; if_req = 1; if_addr = 'h200; dm_req = 1; dm_we = 0; dm_addr = 'h4000;
    dm_func3 = 3'b010; mem_rdata = '0;
    seq = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) begin
      got = "-";
      for (int c = 0; c < 8 && got == "-"; c++) begin
        @(negedge clk);
        if (if_gnt && dm_gnt) got = "B";
        else if (dm_gnt)      got = "D";
        else if (if_gnt)      got = "I";
        @(posedge clk);
        #1;
      end
      chk($sformatf("streak_grant%0d", k), 32'(got), 32'(seq[k]));
    end
    if_req = 0; dm_req = 0;
    repeat (4) @(posedge clk);
    #1;

    // LATENCY=1: held fetch request gets a grant every other cycle, VALID aligned with GNT.
    if_req2 = 1; if_addr2 = 'h300;
    for (int c = 0; c < 6; c++) begin
      mem_rdata2 = 32'h100 + 32'(c);
      @(negedge clk);
      chk($sformatf("lat1_gnt_c%0d", c), 32'(if_gnt2), 32'((c % 2) == 0));
      chk($sformatf("lat1_valid_c%0d", c), 32'(if_valid2), 32'((c >= 2) && ((c % 2) == 0)));
      if ((c >= 2) && ((c % 2) == 0))
        chk($sformatf("lat1_rdata_c%0d", c), if_rdata2, 32'h100 + 32'(c - 1));
      @(posedge clk);
      #1;
    end
    if_req2 = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, memory access length in cycles; legal range 1..7.
REQ-002 Parameter MAX_DM_STREAK, default 4, consecutive data grants allowed while fetch waits; legal range 1..15.
REQ-003 CLK  input  1  single clock, all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 IF_REQ  input  1  fetch request, held until IF_GNT.
REQ-006 IF_ADDR  input  32  fetch byte address.
REQ-007 IF_GNT  output  1  fetch request accepted this cycle.
REQ-008 IF_VALID  output  1  one-cycle pulse, IF_RDATA valid.
REQ-009 IF_RDATA  output  32  fetched instruction word.
REQ-010 DM_REQ  input  1  data request, held until DM_GNT.
REQ-011 DM_WE  input  1  1 = store, 0 = load.
REQ-012 DM_ADDR  input  32  data byte address.
REQ-013 DM_WDATA  input  32  store data.
REQ-014 DM_FUNC3  input  3  access size/sign code.
REQ-015 DM_GNT  output  1  data request accepted this cycle.
REQ-016 DM_VALID  output  1  one-cycle completion pulse; carries load data for loads, acknowledges stores.
REQ-017 DM_RDATA  output  32  load data.
REQ-018 MEM_EN, MEM_WE  output  1 each  memory port enable and write enable.
REQ-019 MEM_ADDR, MEM_WDATA  output  32 each  memory port address and write data.
REQ-020 MEM_FUNC3  output  3  memory port size code.
REQ-021 MEM_RDATA  input  32  memory read data, valid in the last cycle of an access.
REQ-022 BUSY  output  1  high when state is not IDLE.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, ACC_IF and ACC_DM.
REQ-024 Grants SHALL be issued combinationally, only in IDLE, and at most one per cycle; IF_GNT and DM_GNT SHALL never be high together.
REQ-025 Priority in IDLE: DM_REQ wins over IF_REQ, except when streak >= MAX_DM_STREAK and IF_REQ=1, in which case IF wins.
REQ-026 The 4-bit streak counter SHALL increment (saturating at 15) on each DM grant, and SHALL clear on an IF grant or on any IDLE cycle with DM_REQ=0.
REQ-027 On a grant, the requester's address, write enable, write data and FUNC3 SHALL be registered. IF accesses SHALL register WE=0, WDATA=0 and FUNC3=3'b010. The FSM SHALL then enter ACC_IF or ACC_DM.
REQ-028 In ACC_*, MEM_EN SHALL be 1 and the MEM_* outputs SHALL be driven from the registered values for exactly LATENCY cycles, timed by a down-counter loaded with LATENCY-1.
REQ-029 In IDLE, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA and MEM_FUNC3 SHALL all be 0.
REQ-030 In the final access cycle (counter=0), MEM_RDATA SHALL be captured into the owner's RDATA register and the FSM SHALL return to IDLE.
REQ-031 The owner's VALID SHALL pulse in the cycle after the final access cycle. That cycle is IDLE, so a new grant is allowed in the same cycle.
REQ-032 Grant-to-VALID latency SHALL be LATENCY+1 cycles. Sustained throughput SHALL be one access per LATENCY+1 cycles.
REQ-033 For stores, DM_RDATA SHALL be loaded with 0.
REQ-034 IF_RDATA and DM_RDATA SHALL hold their value between VALID pulses.
REQ-035 Request inputs that change during ACC_* SHALL have no effect on the access in flight.
REQ-036 A request deasserted before its grant SHALL be dropped, with no VALID.

Reset
REQ-037 When RESET=1 at a clock edge, the following SHALL all become 0: state (IDLE), counter, streak, registered address, registered data, registered control, IF_RDATA, DM_RDATA, IF_VALID and DM_VALID.
REQ-038 While RESET=1, IF_GNT and DM_GNT SHALL be 0.
REQ-039 Reset asserted during ACC_* SHALL abort the access with no VALID pulse. The next grant SHALL be possible in the first cycle after RESET falls.

Verification
REQ-040 With LATENCY=2, IF_REQ=1, IF_ADDR=0x40 and MEM_RDATA=0x00500093 -> IF_GNT at T0; MEM_EN=1 and MEM_ADDR=0x40 at T1-T2; IF_VALID=1 and IF_RDATA=0x00500093 at T3.
REQ-041 With IF_REQ and DM_REQ (load, 0x1000) both rising at T0 -> DM_GNT at T0, DM_VALID at T3, IF_GNT at T3, IF_VALID at T6.
REQ-042 With DM_REQ held high (MAX_DM_STREAK=4) and IF_REQ held high -> four DM grants, then one IF grant, then the DM streak resumes.
REQ-043 Store DM_WE=1, DM_ADDR=0x2000, DM_WDATA=0xDEADBEEF, DM_FUNC3=3'b010 -> MEM_WE=1 with those values for 2 cycles; DM_VALID=1 and DM_RDATA=0 at T3.
REQ-044 RESET=1 at T2 of an IF access -> BUSY=0 and no IF_VALID at T3; a request at T3 with RESET=0 is granted at T3.
REQ-045 With LATENCY=1, back-to-back IF requests -> one grant every 2 cycles; GNT and VALID coincide from the second access on.
